// File: rtl/hit_tracker_if.sv
// Game-side signal bundle for hit_tracker: light/keypad inputs, game settings
// and the scoring outputs that feed the HEX decoders.
interface hit_tracker_if #(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned LIVES_W = 2
);
   logic               start;
   logic               light_on;
   logic [3:0]         light_coord;
   logic               valid_key;
   logic [3:0]         key;
   logic [CNT_W-1:0]   max_hits;
   logic [LIVES_W-1:0] total_lives;
   logic [CNT_W-1:0]   total_points;
   logic [CNT_W-1:0]   light_flicks;
   logic [LIVES_W-1:0] lives_left;
   logic               hit;
   logic               miss;
   logic               gameover;

   // Game controller / stimulus side
   modport master (
      output start, light_on, light_coord, valid_key, key, max_hits, total_lives,
      input  total_points, light_flicks, lives_left, hit, miss, gameover
   );

   // Scoring stage side
   modport slave (
      input  start, light_on, light_coord, valid_key, key, max_hits, total_lives,
      output total_points, light_flicks, lives_left, hit, miss, gameover
   );
endinterface

// File: rtl/hit_tracker.sv
// Scoring stage: tracks each light window (light_on high period), credits at
// most one hit per window on a matching key press, counts flicks, misses and
// lives, and raises gameover when the flick limit or lives run out.
module hit_tracker #(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned LIVES_W = 2
) (
   input logic         clk,
   input logic         reset,
   hit_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      WINDOW = 2'd2,
      OVER   = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   total_points;
   logic [CNT_W-1:0]   light_flicks;
   logic [LIVES_W-1:0] lives_left;
   logic               hit_q;
   logic               miss_q;
   logic               gameover_q;
   logic               valid_key_q;
   logic               light_on_q;
   logic               hit_flag;

   logic               key_edge;
   logic               rise;
   logic               fall;
   logic               key_match;
   logic               window_missed;
   logic [CNT_W-1:0]   points_inc;
   logic [CNT_W-1:0]   flicks_inc;
   logic [LIVES_W-1:0] lives_dec;
   logic               end_game;

   // Edge detection, saturating increments and end-of-window decisions
   always_comb begin
      key_edge      = bus.valid_key & ~valid_key_q;
      rise          = bus.light_on & ~light_on_q;
      fall          = ~bus.light_on & light_on_q;
      key_match     = key_edge & (bus.key == bus.light_coord) & ~hit_flag;
      // A hit credited in the closing cycle itself still prevents the miss
      window_missed = ~hit_flag & ~key_match;
      points_inc    = (total_points == '1) ? total_points : total_points + 1'b1;
      flicks_inc    = (light_flicks == '1) ? light_flicks : light_flicks + 1'b1;
      lives_dec     = lives_left;
      if (window_missed && (bus.total_lives != '0) && (lives_left != '0))
         lives_dec = lives_left - 1'b1;
      end_game = ((bus.max_hits != '0) && (flicks_inc == bus.max_hits)) ||
                 ((bus.total_lives != '0) && (lives_dec == '0));
   end

   // Game FSM with registered counters and pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         total_points <= '0;
         light_flicks <= '0;
         lives_left   <= bus.total_lives;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         gameover_q   <= 1'b0;
         valid_key_q  <= 1'b0;
         light_on_q   <= 1'b0;
         hit_flag     <= 1'b0;
      end else begin
         valid_key_q <= bus.valid_key;
         light_on_q  <= bus.light_on;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         case (state)
            IDLE: begin
               lives_left <= bus.total_lives;
               if (bus.start) begin
                  // A rise coinciding with arming opens the window directly
                  if (rise) begin
                     state    <= WINDOW;
                     hit_flag <= 1'b0;
                  end else begin
                     state <= ARMED;
                  end
               end
            end
            ARMED: begin
               if (bus.start && rise) begin
                  state    <= WINDOW;
                  hit_flag <= 1'b0;
               end
            end
            WINDOW: begin
               if (bus.start) begin
                  if (key_match) begin
                     total_points <= points_inc;
                     hit_q        <= 1'b1;
                     hit_flag     <= 1'b1;
                  end
                  if (fall) begin
                     light_flicks <= flicks_inc;
                     miss_q       <= window_missed;
                     lives_left   <= lives_dec;
                     if (end_game) begin
                        state      <= OVER;
                        gameover_q <= 1'b1;
                     end else begin
                        state <= ARMED;
                     end
                  end
               end
            end
            OVER: begin
               gameover_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.total_points = total_points;
   assign bus.light_flicks = light_flicks;
   assign bus.lives_left   = lives_left;
   assign bus.hit          = hit_q;
   assign bus.miss         = miss_q;
   assign bus.gameover     = gameover_q;

endmodule

// File: tb/tb_hit_tracker.sv
// Directed bench for hit_tracker: each step drives one cycle of inputs, queues
// the outputs expected after that edge, and compares them one tick later.
module tb_hit_tracker;

   logic clk;
   logic reset;

   hit_tracker_if #(.CNT_W(6), .LIVES_W(2)) bus ();

   hit_tracker #(.CNT_W(6), .LIVES_W(2)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct packed {
      logic [5:0] pts;
      logic [5:0] flk;
      logic [1:0] lv;
      logic       hit;
      logic       miss;
      logic       go;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input int unsigned p, input int unsigned f, input int unsigned l,
                               input logic h, input logic m, input logic g);
      exp_t e;
      e.pts  = 6'(p);
      e.flk  = 6'(f);
      e.lv   = 2'(l);
      e.hit  = h;
      e.miss = m;
      e.go   = g;
      return e;
   endfunction

   task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, queue expectation, compare after the edge
   task automatic step(input string name, input logic rst, input logic st, input logic lo,
                       input logic vk, input logic [3:0] k, input exp_t e);
      exp_t got;
      reset         = rst;
      bus.start     = st;
      bus.light_on  = lo;
      bus.valid_key = vk;
      bus.key       = k;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check({name, ".points"},   32'(bus.total_points), 32'(got.pts));
      check({name, ".flicks"},   32'(bus.light_flicks), 32'(got.flk));
      check({name, ".lives"},    32'(bus.lives_left),   32'(got.lv));
      check({name, ".hit"},      32'(bus.hit),          32'(got.hit));
      check({name, ".miss"},     32'(bus.miss),         32'(got.miss));
      check({name, ".gameover"}, 32'(bus.gameover),     32'(got.go));
   endtask

   // Rise, correct press, fall with key released
   task automatic hit_window(input string name, input int unsigned p, input int unsigned f,
                             input int unsigned l, input logic go_end);
      step({name, ".rise"},  1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(p,     f,     l, 1'b0, 1'b0, 1'b0));
      step({name, ".press"}, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(p + 1, f,     l, 1'b1, 1'b0, 1'b0));
      step({name, ".fall"},  1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(p + 1, f + 1, l, 1'b0, 1'b0, go_end));
   endtask

   initial begin
      reset           = 1'b0;
      bus.start       = 1'b0;
      bus.light_on    = 1'b0;
      bus.light_coord = 4'h2;
      bus.valid_key   = 1'b0;
      bus.key         = 4'h0;
      bus.max_hits    = 6'd0;
      bus.total_lives = 2'd1;
      @(posedge clk);
      #1;

      // Reset state with one life
      step("t1.reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, mk(0, 0, 1, 1'b0, 1'b0, 1'b0));

      // Three hits against max_hits=3, lives disabled
      bus.max_hits    = 6'd3;
      bus.total_lives = 2'd0;
      step("t2.reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
      step("t2.start", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0));
      for (int unsigned w = 0; w < 3; w++)
         hit_window("t2.win", w, w, 0, (w == 2));
      step("t2.over", 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(3, 3, 0, 1'b0, 1'b0, 1'b1));

      // Wrong key, miss loses the last life
      bus.max_hits    = 6'd0;
      bus.total_lives = 2'd1;
      step("t3.reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, mk(0, 0, 1, 1'b0, 1'b0, 1'b0));
      step("t3.start", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 0, 1, 1'b0, 1'b0, 1'b0));
      step("t3.rise",  1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(0, 0, 1, 1'b0, 1'b0, 1'b0));
      step("t3.wrong", 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, mk(0, 0, 1, 1'b0, 1'b0, 1'b0));
      step("t3.fall",  1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 1, 0, 1'b0, 1'b1, 1'b1));

      // Double press in one window
      bus.total_lives = 2'd2;
      step("t4.reset",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0, mk(0, 0, 2, 1'b0, 1'b0, 1'b0));
      step("t4.start",   1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 0, 2, 1'b0, 1'b0, 1'b0));
      step("t4.rise",    1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(0, 0, 2, 1'b0, 1'b0, 1'b0));
      step("t4.press1",  1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(1, 0, 2, 1'b1, 1'b0, 1'b0));
      step("t4.release", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(1, 0, 2, 1'b0, 1'b0, 1'b0));
      step("t4.press2",  1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(1, 0, 2, 1'b0, 1'b0, 1'b0));
      step("t4.fall",    1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(1, 1, 2, 1'b0, 1'b0, 1'b0));

      // Correct press in the same cycle as fall
      step("t5.rise",     1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(1, 1, 2, 1'b0, 1'b0, 1'b0));
      step("t5.fallhit",  1'b1, 1'b1, 1'b0, 1'b1, 4'h2, mk(2, 2, 2, 1'b1, 1'b0, 1'b0));
      step("t5.release",  1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(2, 2, 2, 1'b0, 1'b0, 1'b0));
      // Key held across rise scores nothing and misses
      step("t5.armpress", 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, mk(2, 2, 2, 1'b0, 1'b0, 1'b0));
      step("t5.heldrise", 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(2, 2, 2, 1'b0, 1'b0, 1'b0));
      step("t5.heldfall", 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, mk(2, 3, 1, 1'b0, 1'b1, 1'b0));
      step("t5.release2", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(2, 3, 1, 1'b0, 1'b0, 1'b0));
      // Rise seen while frozen is lost
      step("t5.frzrise",  1'b1, 1'b0, 1'b1, 1'b0, 4'h0, mk(2, 3, 1, 1'b0, 1'b0, 1'b0));
      step("t5.resume",   1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(2, 3, 1, 1'b0, 1'b0, 1'b0));
      step("t5.lostfall", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(2, 3, 1, 1'b0, 1'b0, 1'b0));
      step("t5.rise3",    1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(2, 3, 1, 1'b0, 1'b0, 1'b0));
      step("t5.lastmiss", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(2, 4, 0, 1'b0, 1'b1, 1'b1));

      // Reset mid-window abandons it
      bus.total_lives = 2'd3;
      step("t6.reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, mk(0, 0, 3, 1'b0, 1'b0, 1'b0));
      step("t6.start", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 0, 3, 1'b0, 1'b0, 1'b0));
      for (int unsigned w = 0; w < 4; w++)
         hit_window("t6.win", w, w, 3, 1'b0);
      step("t6.rise",   1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(4, 4, 3, 1'b0, 1'b0, 1'b0));
      step("t6.midrst", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, mk(0, 0, 3, 1'b0, 1'b0, 1'b0));
      step("t6.fall",   1'b1, 1'b1, 1'b0, 1'b0, 4'h0, mk(0, 0, 3, 1'b0, 1'b0, 1'b0));
      step("t6.rise2",  1'b1, 1'b1, 1'b1, 1'b0, 4'h0, mk(0, 0, 3, 1'b0, 1'b0, 1'b0));
      step("t6.press",  1'b1, 1'b1, 1'b1, 1'b1, 4'h2, mk(1, 0, 3, 1'b1, 1'b0, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
